tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Upstream feeder for tone_generator: turns a one-cycle play request (tone select + duration) into a timed frequency word, followed by a silent gap.
- Drives tone_generator.frequency directly; frequency = 0 means silence.
- Game FSM issues requests and waits on busy/done.
- Timing is in milliseconds, derived from the shared ticks_per_ms input.

Parameters:
- FREQ_0, 209, frequency (Hz) for tone_sel 0 (green)
- FREQ_1, 252, frequency for tone_sel 1 (red)
- FREQ_2, 310, frequency for tone_sel 2 (yellow)
- FREQ_3, 415, frequency for tone_sel 3 (blue)
- FREQ_ERR, 42, frequency for tone_sel 4 (error buzz)
- FREQ_WIN, 523, frequency for tone_sel 5 (win chirp)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ticks_per_ms  in  16  clk cycles per millisecond (0 treated as 1)
- start  in  1  play request, sampled each cycle
- tone_sel  in  3  tone index; 0-5 valid, 6-7 give silence
- duration_ms  in  12  tone length in ms
- gap_ms  in  8  silence after tone, in ms
- abort  in  1  cancel current request
- frequency  out  10  to tone_generator; 0 = silent
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state IDLE, frequency 0, busy 0, done 0, all counters 0.
- States:
  - IDLE: frequency 0, busy 0.
  - PLAY: frequency = table[sel_q], busy 1.
  - GAP: frequency 0, busy 1.
  - FINISH: exactly one cycle, done 1, busy 0, frequency 0.
- Acceptance:
  - start is accepted only in IDLE or FINISH (busy = 0) and is ignored while busy = 1.
  - On accept, latch tone_sel, duration_ms, gap_ms and ticks_per_ms (max with 1) into sel_q, dur_q, gap_q, tpm_q.
  - Later input changes have no effect on the request in progress.
- Latency: start high at edge N moves the FSM to PLAY at edge N. frequency is registered and equals the table value in the cycle after the start cycle.
- Timebase:
  - tick_cnt counts 0..tpm_q-1; at tpm_q-1 it wraps to 0 and ms_cnt increments.
  - Both counters clear on every state entry.
- PLAY lasts exactly dur_q*tpm_q cycles, then GAP.
- GAP lasts exactly gap_q*tpm_q cycles, then FINISH.
- FINISH returns to IDLE, or to PLAY if start is accepted in that cycle, giving back-to-back notes with no dead cycle.
- Zero durations:
  - dur_q = 0: PLAY is skipped and the FSM goes straight to GAP; frequency never leaves 0.
  - gap_q = 0: the FSM goes straight from PLAY to FINISH.
  - Both 0: FINISH is reached the cycle after accept.
- tone_sel 6 or 7: treated as a valid request with frequency 0 throughout; timing is unchanged.
- abort:
  - In PLAY or GAP, abort forces IDLE at the next edge: frequency 0, busy 0, no done pulse.
  - abort has priority over start in the same cycle.
  - abort in IDLE or FINISH has no effect; the FINISH done pulse still occurs.
- Widths:
  - ms_cnt is 12 bits, compared against dur_q or {4'b0, gap_q}.
  - tick_cnt is 16 bits.
  - No multiplier is used; duration is counted in nested counters.
- rst mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- Basic note: ticks_per_ms=4, start with tone_sel=2, duration_ms=3, gap_ms=2 -> frequency=310 for exactly 12 cycles starting the cycle after start, then 0 for 8 cycles, then done=1 for one cycle; busy high for 20 cycles.
- Back-to-back: assert start with tone_sel=0 in the FINISH cycle of the previous note -> no idle cycle; frequency=209 the next cycle; exactly one done pulse per note.
- Ignored start: re-assert start with tone_sel=3 while busy -> the first note completes unchanged; no frequency=415 ever appears.
- Zero/edge lengths: duration_ms=0, gap_ms=1, ticks_per_ms=0 -> frequency stays 0, done after 1 GAP cycle (tpm treated as 1). tone_sel=7 with duration_ms=2 -> frequency 0, done on schedule.
- Abort: abort in cycle 5 of PLAY with tone_sel=4 (42) -> frequency=0 and busy=0 next cycle, done never asserted. Same cycle as start while busy -> abort wins.
- Async reset: pulse rst mid-GAP between clock edges -> frequency, busy, done = 0 immediately. A new start after rst deasserts plays normally.

Source files
------------

// File: rtl/tone_sequencer_if.sv
// Request/response bundle between the game FSM (master) and the tone sequencer (slave).
// The sequencer's frequency output feeds tone_generator directly.
interface tone_sequencer_if;
    logic        start;
    logic [2:0]  tone_sel;
    logic [11:0] duration_ms;
    logic [7:0]  gap_ms;
    logic        abort;
    logic [9:0]  frequency;
    logic        busy;
    logic        done;

    modport master (
        output start, tone_sel, duration_ms, gap_ms, abort,
        input  frequency, busy, done
    );

    modport slave (
        input  start, tone_sel, duration_ms, gap_ms, abort,
        output frequency, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Turns a one-cycle play request into a timed tone followed by a silent gap,
// then a one-cycle done pulse. Timing uses nested ms/tick counters (no multiplier).
module tone_sequencer #(
    parameter logic [9:0] FREQ_0   = 10'd209,
    parameter logic [9:0] FREQ_1   = 10'd252,
    parameter logic [9:0] FREQ_2   = 10'd310,
    parameter logic [9:0] FREQ_3   = 10'd415,
    parameter logic [9:0] FREQ_ERR = 10'd42,
    parameter logic [9:0] FREQ_WIN = 10'd523
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            ticks_per_ms,
    tone_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sel_reg, sel_next;
    logic [11:0] dur_reg, dur_next;
    logic [7:0]  gap_reg, gap_next;
    logic [15:0] tpm_reg, tpm_next;
    logic [15:0] tick_reg, tick_next;
    logic [11:0] ms_reg, ms_next;
    logic [9:0]  freq_reg, freq_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        accept;
    logic        tick_wrap;
    logic        play_end;
    logic        gap_end;

    // Selects 6 and 7 map to silence but still run the full timing.
    logic [9:0]  freq_table [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_freq
            localparam logic [9:0] F = (gi == 0) ? FREQ_0   :
                                       (gi == 1) ? FREQ_1   :
                                       (gi == 2) ? FREQ_2   :
                                       (gi == 3) ? FREQ_3   :
                                       (gi == 4) ? FREQ_ERR :
                                       (gi == 5) ? FREQ_WIN : 10'd0;
            assign freq_table[gi] = F;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        dur_next   = dur_reg;
        gap_next   = gap_reg;
        tpm_next   = tpm_reg;
        tick_next  = tick_reg;
        ms_next    = ms_reg;

        accept    = bus.start && ((state_reg == IDLE) || (state_reg == FINISH));
        tick_wrap = (tick_reg == tpm_reg - 16'd1);
        play_end  = tick_wrap && (ms_reg == dur_reg - 12'd1);
        gap_end   = tick_wrap && (ms_reg == {4'b0, gap_reg} - 12'd1);

        case (state_reg)
            IDLE, FINISH: begin
                if (accept) begin
                    sel_next = bus.tone_sel;
                    dur_next = bus.duration_ms;
                    gap_next = bus.gap_ms;
                    tpm_next = (ticks_per_ms == 16'd0) ? 16'd1 : ticks_per_ms;
                    // Zero-length phases are skipped entirely.
                    if (bus.duration_ms != 12'd0)
                        state_next = PLAY;
                    else if (bus.gap_ms != 8'd0)
                        state_next = GAP;
                    else
                        state_next = FINISH;
                end else begin
                    state_next = IDLE;
                end
            end
            PLAY: begin
                if (bus.abort)
                    state_next = IDLE;
                else if (play_end)
                    state_next = (gap_reg != 8'd0) ? GAP : FINISH;
            end
            GAP: begin
                if (bus.abort)
                    state_next = IDLE;
                else if (gap_end)
                    state_next = FINISH;
            end
            default: state_next = IDLE;
        endcase

        // Counters restart on every state entry, including FINISH->FINISH re-accepts.
        if ((state_next != state_reg) || accept) begin
            tick_next = 16'd0;
            ms_next   = 12'd0;
        end else if ((state_reg == PLAY) || (state_reg == GAP)) begin
            if (tick_wrap) begin
                tick_next = 16'd0;
                ms_next   = ms_reg + 12'd1;
            end else begin
                tick_next = tick_reg + 16'd1;
            end
        end

        freq_next = (state_next == PLAY) ? freq_table[sel_next] : 10'd0;
        busy_next = (state_next == PLAY) || (state_next == GAP);
        done_next = (state_next == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 3'd0;
            dur_reg   <= 12'd0;
            gap_reg   <= 8'd0;
            tpm_reg   <= 16'd0;
            tick_reg  <= 16'd0;
            ms_reg    <= 12'd0;
            freq_reg  <= 10'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            dur_reg   <= dur_next;
            gap_reg   <= gap_next;
            tpm_reg   <= tpm_next;
            tick_reg  <= tick_next;
            ms_reg    <= ms_next;
            freq_reg  <= freq_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.frequency = freq_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: table of single notes plus hand-built
// sequences for back-to-back, ignored start, abort and async reset.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ticks_per_ms;

    tone_sequencer_if bus ();

    tone_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ticks_per_ms (ticks_per_ms),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tpm;
        logic [2:0]  sel;
        logic [11:0] dur;
        logic [7:0]  gap;
        logic [9:0]  exp_freq;
        int          play_cyc;
        int          gap_cyc;
    } vec_t;

    vec_t vecs [8];
    int   pass_cnt = 0;
    int   check_cnt = 0;

    task automatic check_now(input string name, input logic [9:0] f, input logic b, input logic d);
        check_cnt++;
        if (bus.frequency === f && bus.busy === b && bus.done === d)
            pass_cnt++;
        else
            $display("FAIL %s @%0t: frequency=%0d busy=%0b done=%0b, required frequency=%0d busy=%0b done=%0b",
                     name, $time, bus.frequency, bus.busy, bus.done, f, b, d);
    endtask

    // Check the current cycle, advance one clock, n times.
    task automatic expect_cycles(input string name, input logic [9:0] f, input logic b,
                                 input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            check_now(name, f, b, d);
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle start; returns #1 after the accepting edge, then scrambles inputs.
    task automatic send(input logic [15:0] tpm, input logic [2:0] sel,
                        input logic [11:0] dur, input logic [7:0] gap);
        @(negedge clk);
        ticks_per_ms    = tpm;
        bus.tone_sel    = sel;
        bus.duration_ms = dur;
        bus.gap_ms      = gap;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.tone_sel    = 3'd3;
        bus.duration_ms = 12'hfff;
        bus.gap_ms      = 8'hff;
        ticks_per_ms    = 16'd7;
    endtask

    initial begin
        vecs[0] = '{16'd4, 3'd2, 12'd3, 8'd2, 10'd310, 12, 8};
        vecs[1] = '{16'd0, 3'd0, 12'd0, 8'd1, 10'd0,   0,  1};
        vecs[2] = '{16'd1, 3'd7, 12'd2, 8'd0, 10'd0,   2,  0};
        vecs[3] = '{16'd2, 3'd4, 12'd1, 8'd1, 10'd42,  2,  2};
        vecs[4] = '{16'd3, 3'd5, 12'd2, 8'd0, 10'd523, 6,  0};
        vecs[5] = '{16'd1, 3'd1, 12'd0, 8'd0, 10'd0,   0,  0};
        vecs[6] = '{16'd2, 3'd3, 12'd1, 8'd3, 10'd415, 2,  6};
        vecs[7] = '{16'd1, 3'd6, 12'd1, 8'd1, 10'd0,   1,  1};

        rst             = 1'b1;
        ticks_per_ms    = 16'd0;
        bus.start       = 1'b0;
        bus.tone_sel    = 3'd0;
        bus.duration_ms = 12'd0;
        bus.gap_ms      = 8'd0;
        bus.abort       = 1'b0;
        #7;
        check_now("reset", 10'd0, 1'b0, 1'b0);
        #6 rst = 1'b0;
        @(posedge clk);
        #1;
        expect_cycles("idle_after_reset", 10'd0, 1'b0, 1'b0, 2);

        for (int k = 0; k < 8; k++) begin
            $display("note %0d: tpm=%0d sel=%0d dur=%0d gap=%0d expect freq=%0d play=%0d gap=%0d",
                     k, vecs[k].tpm, vecs[k].sel, vecs[k].dur, vecs[k].gap,
                     vecs[k].exp_freq, vecs[k].play_cyc, vecs[k].gap_cyc);
            send(vecs[k].tpm, vecs[k].sel, vecs[k].dur, vecs[k].gap);
            expect_cycles($sformatf("vec%0d_play", k), vecs[k].exp_freq, 1'b1, 1'b0, vecs[k].play_cyc);
            expect_cycles($sformatf("vec%0d_gap", k), 10'd0, 1'b1, 1'b0, vecs[k].gap_cyc);
            expect_cycles($sformatf("vec%0d_finish", k), 10'd0, 1'b0, 1'b1, 1);
            expect_cycles($sformatf("vec%0d_idle", k), 10'd0, 1'b0, 1'b0, 1);
        end

        $display("seq back_to_back: sel1 then sel0 started in FINISH");
        send(16'd2, 3'd1, 12'd1, 8'd1);
        expect_cycles("b2b_play1", 10'd252, 1'b1, 1'b0, 2);
        expect_cycles("b2b_gap1", 10'd0, 1'b1, 1'b0, 2);
        check_now("b2b_finish1", 10'd0, 1'b0, 1'b1);
        send(16'd1, 3'd0, 12'd1, 8'd0);
        expect_cycles("b2b_play2", 10'd209, 1'b1, 1'b0, 1);
        expect_cycles("b2b_finish2", 10'd0, 1'b0, 1'b1, 1);
        expect_cycles("b2b_idle", 10'd0, 1'b0, 1'b0, 2);

        $display("seq ignored_start: sel3 requested while sel0 plays");
        send(16'd1, 3'd0, 12'd4, 8'd2);
        expect_cycles("ign_play_a", 10'd209, 1'b1, 1'b0, 2);
        check_now("ign_play_b", 10'd209, 1'b1, 1'b0);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.tone_sel    = 3'd3;
        bus.duration_ms = 12'd1;
        bus.gap_ms      = 8'd0;
        ticks_per_ms    = 16'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        expect_cycles("ign_play_c", 10'd209, 1'b1, 1'b0, 1);
        expect_cycles("ign_gap", 10'd0, 1'b1, 1'b0, 2);
        expect_cycles("ign_finish", 10'd0, 1'b0, 1'b1, 1);
        expect_cycles("ign_idle", 10'd0, 1'b0, 1'b0, 2);

        $display("seq abort: abort+start in PLAY cycle 5 of error buzz");
        send(16'd2, 3'd4, 12'd4, 8'd1);
        expect_cycles("abort_play", 10'd42, 1'b1, 1'b0, 4);
        check_now("abort_play5", 10'd42, 1'b1, 1'b0);
        @(negedge clk);
        bus.abort       = 1'b1;
        bus.start       = 1'b1;
        bus.tone_sel    = 3'd3;
        bus.duration_ms = 12'd2;
        bus.gap_ms      = 8'd0;
        ticks_per_ms    = 16'd1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        expect_cycles("abort_idle", 10'd0, 1'b0, 1'b0, 12);

        $display("seq abort_in_idle: abort with start in IDLE still accepts");
        bus.abort = 1'b1;
        send(16'd1, 3'd1, 12'd1, 8'd0);
        bus.abort = 1'b0;
        expect_cycles("idle_abort_play", 10'd252, 1'b1, 1'b0, 1);
        expect_cycles("idle_abort_finish", 10'd0, 1'b0, 1'b1, 1);
        expect_cycles("idle_abort_idle", 10'd0, 1'b0, 1'b0, 1);

        $display("seq async_reset: rst pulsed mid-GAP, then a fresh note");
        send(16'd2, 3'd2, 12'd1, 8'd3);
        expect_cycles("rst_play", 10'd310, 1'b1, 1'b0, 2);
        expect_cycles("rst_gap", 10'd0, 1'b1, 1'b0, 2);
        check_now("rst_gap3", 10'd0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_now("rst_async", 10'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        expect_cycles("rst_idle", 10'd0, 1'b0, 1'b0, 8);
        send(16'd1, 3'd5, 12'd2, 8'd1);
        expect_cycles("rst_new_play", 10'd523, 1'b1, 1'b0, 2);
        expect_cycles("rst_new_gap", 10'd0, 1'b1, 1'b0, 1);
        expect_cycles("rst_new_finish", 10'd0, 1'b0, 1'b1, 1);
        expect_cycles("rst_new_idle", 10'd0, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
